// File: rtl/vga_scanout.sv
`default_nettype none
// ============================================================================
//  Module      : vga_scanout
//  Description : Frame scan-out engine. Fetches one frame of 32-bit pixels
//                from framebuffer memory over a pipelined read master,
//                buffers them in a credit-managed FIFO and pops one pixel per
//                active display cycle, keeping sync/blank aligned with the
//                pixel stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_scanout #(
  parameter int          FIFO_DEPTH    = 512,
  parameter int          ADDR_W        = 32,
  parameter logic [23:0] UNDERFLOW_RGB = 24'hFF00FF
) (
  input  logic              pixel_clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] fb_base,
  input  logic [11:0]       h_res,
  input  logic [11:0]       v_res,
  input  logic              display_active,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              blank_n_in,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  input  logic              mem_waitrequest,
  input  logic [31:0]       mem_readdata,
  input  logic              mem_readdatavalid,
  output logic [23:0]       pixel_rgb,
  output logic              hsync,
  output logic              vsync,
  output logic              blank_n,
  output logic              underflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]  C_CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  C_DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W:0]    C_DEPTH_OCC = (CNT_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]  C_PTR_ONE   = PTR_W'(1);
  localparam logic [ADDR_W-1:0] C_ADDR_STEP = ADDR_W'(4);
  localparam logic [23:0]       C_REM_ONE   = 24'd1;

  typedef enum logic [1:0] {
    S_WAIT_FRAME = 2'd0,
    S_FLUSH      = 2'd1,
    S_FETCH      = 2'd2,
    S_DONE       = 2'd3
  } state_t;

  // Control state
  state_t            state_q, state_d;
  logic              vsync_prev_q;
  logic [ADDR_W-1:0] addr_q, addr_d;          // next address to request
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;  // address of the live request
  logic [23:0]       remaining_q, remaining_d;
  logic              req_q, req_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;

  // FIFO state
  logic [23:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  fifo_count_q, fifo_count_d;

  // Output state
  logic [23:0]       pixel_rgb_q, pixel_rgb_d;
  logic              underflow_q, underflow_d;
  logic              hsync_q, vsync_q, blank_n_q;

  // Combinational helpers
  logic              frame_start;
  logic              accept;
  logic              hold;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic [23:0]       frame_pixels;
  logic [CNT_W:0]    occ_next;
  logic              unused_alpha;

  // The alpha byte of each pixel word carries nothing for the DAC.
  assign unused_alpha = ^mem_readdata[31:24];

  assign frame_start  = vsync_prev_q & ~vsync_in;
  assign accept       = req_q & ~mem_waitrequest;
  assign hold         = req_q &  mem_waitrequest;
  assign fifo_empty   = (fifo_count_q == '0);
  assign pop          = display_active & ~fifo_empty;
  // Words returning while flushing belong to an abandoned frame; the clear on
  // a frame-start cycle also drops any word returning in that same cycle.
  assign push         = mem_readdatavalid & (state_q != S_FLUSH) & ~frame_start &
                        ((fifo_count_q != C_DEPTH_CNT) | pop);
  assign frame_pixels = {12'd0, h_res} * {12'd0, v_res};
  assign occ_next     = {1'b0, fifo_count_d} + {1'b0, outstanding_d};

  assign mem_read     = req_q;
  assign mem_address  = mem_addr_q;
  assign pixel_rgb    = pixel_rgb_q;
  assign underflow    = underflow_q;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign blank_n      = blank_n_q;

  // Outstanding-read counter and FIFO pointer/count next-state.
  always_comb begin
    outstanding_d = outstanding_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    fifo_count_d  = fifo_count_q;

    if (accept && !(mem_readdatavalid && (outstanding_q != '0))) begin
      outstanding_d = outstanding_q + C_CNT_ONE;
    end else if (!accept && mem_readdatavalid && (outstanding_q != '0)) begin
      outstanding_d = outstanding_q - C_CNT_ONE;
    end

    if (frame_start) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      fifo_count_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + C_PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + C_PTR_ONE;
      if (push && !pop) begin
        fifo_count_d = fifo_count_q + C_CNT_ONE;
      end else if (!push && pop) begin
        fifo_count_d = fifo_count_q - C_CNT_ONE;
      end
    end
  end

  // Fetch FSM: frame latching, flush of stale reads and credit-limited requests.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    req_d       = req_q;
    mem_addr_d  = mem_addr_q;

    case (state_q)
      S_WAIT_FRAME: begin
        req_d = 1'b0;
        if (frame_start) begin
          state_d     = S_FLUSH;
          addr_d      = fb_base;
          remaining_d = frame_pixels;
        end
      end

      S_FLUSH: begin
        // A request left over from the old frame is held until accepted.
        if (accept) req_d = 1'b0;
        if (frame_start) begin
          addr_d      = fb_base;
          remaining_d = frame_pixels;
        end else if ((outstanding_q == '0) && !req_q) begin
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        if (frame_start) begin
          state_d     = S_FLUSH;
          addr_d      = fb_base;
          remaining_d = frame_pixels;
          if (accept) req_d = 1'b0;
        end else begin
          if (accept) begin
            addr_d      = addr_q + C_ADDR_STEP;
            remaining_d = remaining_q - C_REM_ONE;
          end
          if (!hold) begin
            // Occupancy counts FIFO words plus words in flight, so an
            // accepted read always has a FIFO slot waiting for it.
            req_d = (remaining_d != '0) && (occ_next < C_DEPTH_OCC);
            if (req_d) mem_addr_d = addr_d;
          end
          if (!req_d && (remaining_d == '0)) state_d = S_DONE;
        end
      end

      S_DONE: begin
        req_d = 1'b0;
        if (frame_start) begin
          state_d     = S_FLUSH;
          addr_d      = fb_base;
          remaining_d = frame_pixels;
        end
      end

      default: begin
        state_d = S_WAIT_FRAME;
        req_d   = 1'b0;
      end
    endcase
  end

  // Pixel pop: head of FIFO, underflow colour when empty, black when inactive.
  always_comb begin
    pixel_rgb_d = 24'd0;
    underflow_d = underflow_q;
    if (display_active) begin
      if (fifo_empty) begin
        pixel_rgb_d = UNDERFLOW_RGB;
        underflow_d = 1'b1;
      end else begin
        pixel_rgb_d = fifo_mem[rd_ptr_q];
      end
    end
  end

  // Fetch control registers.
  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_WAIT_FRAME;
      vsync_prev_q  <= 1'b0;
      addr_q        <= '0;
      mem_addr_q    <= '0;
      remaining_q   <= '0;
      req_q         <= 1'b0;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      vsync_prev_q  <= vsync_in;
      addr_q        <= addr_d;
      mem_addr_q    <= mem_addr_d;
      remaining_q   <= remaining_d;
      req_q         <= req_d;
      outstanding_q <= outstanding_d;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
    end
  end

  // FIFO storage; contents need no reset since the count gates every read.
  always_ff @(posedge pixel_clock) begin
    if (push) fifo_mem[wr_ptr_q] <= mem_readdata[23:0];
  end

  // Output stage: pixel, sticky underflow and one-cycle-delayed timing signals.
  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      pixel_rgb_q <= 24'd0;
      underflow_q <= 1'b0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      blank_n_q   <= 1'b0;
    end else begin
      pixel_rgb_q <= pixel_rgb_d;
      underflow_q <= underflow_d;
      hsync_q     <= hsync_in;
      vsync_q     <= vsync_in;
      blank_n_q   <= blank_n_in;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_scanout.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_scanout
//  Description : Directed self-checking bench for vga_scanout with a simple
//                pipelined memory responder (fixed latency, optional stall).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_scanout;

  localparam int DEPTH = 16;

  logic        pixel_clock;
  logic        reset_n;
  logic [31:0] fb_base;
  logic [11:0] h_res;
  logic [11:0] v_res;
  logic        display_active;
  logic        hsync_in;
  logic        vsync_in;
  logic        blank_n_in;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;
  logic        mem_readdatavalid;
  logic [23:0] pixel_rgb;
  logic        hsync;
  logic        vsync;
  logic        blank_n;
  logic        underflow;

  int vectors    = 0;
  int miscompares = 0;

  vga_scanout #(
    .FIFO_DEPTH    (DEPTH),
    .ADDR_W        (32),
    .UNDERFLOW_RGB (24'hFF00FF)
  ) dut (
    .pixel_clock       (pixel_clock),
    .reset_n           (reset_n),
    .fb_base           (fb_base),
    .h_res             (h_res),
    .v_res             (v_res),
    .display_active    (display_active),
    .hsync_in          (hsync_in),
    .vsync_in          (vsync_in),
    .blank_n_in        (blank_n_in),
    .mem_address       (mem_address),
    .mem_read          (mem_read),
    .mem_waitrequest   (mem_waitrequest),
    .mem_readdata      (mem_readdata),
    .mem_readdatavalid (mem_readdatavalid),
    .pixel_rgb         (pixel_rgb),
    .hsync             (hsync),
    .vsync             (vsync),
    .blank_n           (blank_n),
    .underflow         (underflow)
  );

  initial pixel_clock = 1'b0;
  always #5 pixel_clock = ~pixel_clock;

  // ---------------- memory responder ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        pipe[$];
  req_t        r_out;
  req_t        r_new;
  logic [31:0] acc_log[$];
  logic [31:0] stall_log[$];
  int          cyc        = 0;
  int          mem_lat    = 1;
  bit          mem_stall  = 1'b0;
  int          stall_idx  = -1;
  int          stall_left = 0;
  int          acc_count  = 0;
  int          ret_count  = 0;
  int          max_outst  = 0;

  function automatic logic [23:0] exp_rgb(input logic [31:0] a);
    return a[23:0] ^ 24'h13579B;
  endfunction

  always @(negedge pixel_clock) begin
    cyc++;
    if (!reset_n) begin
      pipe.delete();
      mem_readdatavalid = 1'b0;
      mem_waitrequest   = 1'b0;
      mem_readdata      = 32'd0;
    end else begin
      mem_readdatavalid = 1'b0;
      if (pipe.size() > 0 && pipe[0].due <= cyc) begin
        r_out             = pipe.pop_front();
        mem_readdata      = {8'hA5, exp_rgb(r_out.addr)};
        mem_readdatavalid = 1'b1;
        ret_count++;
      end
      mem_waitrequest = mem_stall;
      if (mem_read && acc_count == stall_idx && stall_left > 0) begin
        mem_waitrequest = 1'b1;
        stall_left--;
        stall_log.push_back(mem_address);
      end
      if (mem_read && !mem_waitrequest) begin
        acc_log.push_back(mem_address);
        r_new.addr = mem_address;
        r_new.due  = cyc + mem_lat;
        pipe.push_back(r_new);
        acc_count++;
      end
      if (acc_count - ret_count > max_outst) max_outst = acc_count - ret_count;
    end
  end

  // ---------------- helpers (stimulus only) ----------------
  task automatic apply_reset();
    @(negedge pixel_clock);
    reset_n        = 1'b0;
    display_active = 1'b0;
    hsync_in       = 1'b1;
    vsync_in       = 1'b1;
    blank_n_in     = 1'b0;
    mem_stall      = 1'b0;
    stall_idx      = -1;
    stall_left     = 0;
    mem_lat        = 1;
    repeat (3) @(negedge pixel_clock);
    acc_count = 0;
    ret_count = 0;
    max_outst = 0;
    acc_log.delete();
    stall_log.delete();
    reset_n = 1'b1;
  endtask

  task automatic frame_start_pulse();
    @(negedge pixel_clock);
    vsync_in = 1'b0;
    @(negedge pixel_clock);
    vsync_in = 1'b1;
  endtask

  task automatic wait_accepts(input int n, input int budget);
    for (int k = 0; k < budget && acc_count < n; k++) @(negedge pixel_clock);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bit seen_read;
    @(negedge pixel_clock);
    reset_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      display_active = 1'($urandom);
      hsync_in       = 1'($urandom);
      vsync_in       = 1'($urandom);
      blank_n_in     = 1'($urandom);
      fb_base        = $urandom;
      h_res          = 12'($urandom);
      v_res          = 12'($urandom);
      @(negedge pixel_clock);
      vectors++;
      if ({mem_read, mem_address, pixel_rgb, hsync, vsync, blank_n, underflow} !== 62'd0)
        begin miscompares++;
          $display("FAIL reset_outputs: got rd=%b addr=%h rgb=%h hs=%b vs=%b bn=%b uf=%b want all 0",
                   mem_read, mem_address, pixel_rgb, hsync, vsync, blank_n, underflow); end
    end
    display_active = 1'b0;
    vsync_in       = 1'b1;
    fb_base        = 32'h0000_0400;
    h_res          = 12'd4;
    v_res          = 12'd2;
    acc_count = 0; ret_count = 0; acc_log.delete(); stall_log.delete();
    reset_n = 1'b1;
    seen_read = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge pixel_clock);
      if (mem_read !== 1'b0) seen_read = 1'b1;
    end
    vectors++;
    if (seen_read) begin miscompares++;
      $display("FAIL reset_idle_read: mem_read went high before vsync fall, want 0"); end
    frame_start_pulse();
    for (int k = 0; k < 10 && mem_read !== 1'b1; k++) @(negedge pixel_clock);
    vectors++;
    if (mem_read !== 1'b1 || mem_address !== 32'h400) begin miscompares++;
      $display("FAIL reset_first_read: got rd=%b addr=%h want rd=1 addr=00000400", mem_read, mem_address); end
  endtask

  task automatic test_small_frame();
    logic exp_hs, exp_bn;
    apply_reset();
    fb_base = 32'h0000_1000; h_res = 12'd4; v_res = 12'd2;
    frame_start_pulse();
    wait_accepts(8, 60);
    repeat (10) @(negedge pixel_clock);
    vectors++;
    if (acc_count != 8) begin miscompares++;
      $display("FAIL small_read_count: got %0d want 8", acc_count); end
    for (int i = 0; i < 8 && i < acc_log.size(); i++) begin
      vectors++;
      if (acc_log[i] !== 32'h1000 + 32'(4*i)) begin miscompares++;
        $display("FAIL small_addr[%0d]: got %h want %h", i, acc_log[i], 32'h1000 + 32'(4*i)); end
    end
    @(negedge pixel_clock);
    display_active = 1'b1; hsync_in = 1'b0; blank_n_in = 1'b1;
    exp_hs = 1'b0; exp_bn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge pixel_clock);
      vectors++;
      if (pixel_rgb !== exp_rgb(32'h1000 + 32'(4*i))) begin miscompares++;
        $display("FAIL small_pixel[%0d]: got %h want %h", i, pixel_rgb, exp_rgb(32'h1000 + 32'(4*i))); end
      vectors++;
      if ({hsync, vsync, blank_n} !== {exp_hs, 1'b1, exp_bn}) begin miscompares++;
        $display("FAIL small_sync[%0d]: got %b%b%b want %b1%b", i, hsync, vsync, blank_n, exp_hs, exp_bn); end
      if (i < 7) begin
        hsync_in   = ~hsync_in;
        blank_n_in = (i % 3 != 1);
      end else begin
        display_active = 1'b0;
        blank_n_in     = 1'b0;
      end
      exp_hs = hsync_in;
      exp_bn = blank_n_in;
    end
    @(negedge pixel_clock);
    vectors++;
    if (pixel_rgb !== 24'd0 || underflow !== 1'b0 || blank_n !== 1'b0) begin miscompares++;
      $display("FAIL small_idle: got rgb=%h uf=%b bn=%b want 000000/0/0", pixel_rgb, underflow, blank_n); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    fb_base = 32'h0000_1000; h_res = 12'd4; v_res = 12'd2;
    stall_idx = 2; stall_left = 5;
    frame_start_pulse();
    wait_accepts(8, 80);
    repeat (5) @(negedge pixel_clock);
    vectors++;
    if (stall_log.size() != 5) begin miscompares++;
      $display("FAIL bp_stall_cycles: got %0d held cycles want 5", stall_log.size()); end
    for (int i = 0; i < stall_log.size(); i++) begin
      vectors++;
      if (stall_log[i] !== 32'h1008) begin miscompares++;
        $display("FAIL bp_held_addr[%0d]: got %h want 00001008", i, stall_log[i]); end
    end
    vectors++;
    if (acc_log.size() != 8) begin miscompares++;
      $display("FAIL bp_read_count: got %0d want 8", acc_log.size()); end
    for (int i = 0; i < 8 && i < acc_log.size(); i++) begin
      vectors++;
      if (acc_log[i] !== 32'h1000 + 32'(4*i)) begin miscompares++;
        $display("FAIL bp_addr[%0d]: got %h want %h", i, acc_log[i], 32'h1000 + 32'(4*i)); end
    end
  endtask

  task automatic test_credit();
    apply_reset();
    mem_lat = 20;
    fb_base = 32'h0000_8000; h_res = 12'd8; v_res = 12'd4;
    frame_start_pulse();
    repeat (80) @(negedge pixel_clock);
    vectors++;
    if (acc_count != DEPTH) begin miscompares++;
      $display("FAIL credit_reads: got %0d want %0d", acc_count, DEPTH); end
    vectors++;
    if (max_outst > DEPTH) begin miscompares++;
      $display("FAIL credit_outstanding: got max %0d want <= %0d", max_outst, DEPTH); end
    vectors++;
    if (mem_read !== 1'b0) begin miscompares++;
      $display("FAIL credit_read_idle: got mem_read=%b want 0", mem_read); end
    display_active = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge pixel_clock);
      if (i == DEPTH - 1) display_active = 1'b0;
      vectors++;
      if (pixel_rgb !== exp_rgb(32'h8000 + 32'(4*i))) begin miscompares++;
        $display("FAIL credit_pixel[%0d]: got %h want %h", i, pixel_rgb, exp_rgb(32'h8000 + 32'(4*i))); end
    end
    vectors++;
    if (underflow !== 1'b0) begin miscompares++;
      $display("FAIL credit_underflow: got %b want 0", underflow); end
  endtask

  task automatic test_underflow();
    apply_reset();
    mem_stall = 1'b1;
    fb_base = 32'h0000_4000; h_res = 12'd4; v_res = 12'd2;
    frame_start_pulse();
    repeat (5) @(negedge pixel_clock);
    vectors++;
    if (underflow !== 1'b0 || mem_read !== 1'b1 || mem_address !== 32'h4000) begin miscompares++;
      $display("FAIL uf_before: got uf=%b rd=%b addr=%h want 0/1/00004000", underflow, mem_read, mem_address); end
    display_active = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge pixel_clock);
      vectors++;
      if (pixel_rgb !== 24'hFF00FF || underflow !== 1'b1) begin miscompares++;
        $display("FAIL uf_pixel[%0d]: got rgb=%h uf=%b want ff00ff/1", i, pixel_rgb, underflow); end
    end
    display_active = 1'b0;
    @(negedge pixel_clock);
    vectors++;
    if (pixel_rgb !== 24'd0 || underflow !== 1'b1) begin miscompares++;
      $display("FAIL uf_sticky: got rgb=%h uf=%b want 000000/1", pixel_rgb, underflow); end
    repeat (4) @(negedge pixel_clock);
    vectors++;
    if (underflow !== 1'b1) begin miscompares++;
      $display("FAIL uf_sticky_late: got %b want 1", underflow); end
    mem_stall = 1'b0;
  endtask

  task automatic test_midframe();
    apply_reset();
    mem_lat = 6;
    fb_base = 32'h0000_2000; h_res = 12'd8; v_res = 12'd4;
    stall_idx = 3; stall_left = 4;
    frame_start_pulse();
    fb_base = 32'h0000_3000;
    wait_accepts(3, 30);
    @(negedge pixel_clock);
    vsync_in = 1'b0;
    @(negedge pixel_clock);
    vsync_in = 1'b1;
    repeat (60) @(negedge pixel_clock);
    vectors++;
    if (acc_log.size() < 6) begin miscompares++;
      $display("FAIL mid_read_count: got %0d want >= 6", acc_log.size()); end
    else begin
      vectors++;
      if (acc_log[2] !== 32'h2008 || acc_log[3] !== 32'h200C) begin miscompares++;
        $display("FAIL mid_old_reads: got %h %h want 00002008 0000200c", acc_log[2], acc_log[3]); end
      vectors++;
      if (acc_log[4] !== 32'h3000 || acc_log[5] !== 32'h3004) begin miscompares++;
        $display("FAIL mid_new_reads: got %h %h want 00003000 00003004", acc_log[4], acc_log[5]); end
    end
    vectors++;
    if (stall_log.size() == 0 || stall_log[0] !== 32'h200C) begin miscompares++;
      $display("FAIL mid_pending_held: got %0d held cycles want pending 0000200c held", stall_log.size()); end
    display_active = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge pixel_clock);
      if (i == 1) display_active = 1'b0;
      vectors++;
      if (pixel_rgb !== exp_rgb(32'h3000 + 32'(4*i))) begin miscompares++;
        $display("FAIL mid_pixel[%0d]: got %h want %h", i, pixel_rgb, exp_rgb(32'h3000 + 32'(4*i))); end
    end
  endtask

  initial begin
    reset_n        = 1'b1;
    fb_base        = 32'd0;
    h_res          = 12'd0;
    v_res          = 12'd0;
    display_active = 1'b0;
    hsync_in       = 1'b1;
    vsync_in       = 1'b1;
    blank_n_in     = 1'b0;
    mem_waitrequest   = 1'b0;
    mem_readdata      = 32'd0;
    mem_readdatavalid = 1'b0;
    #2;
    test_reset();
    test_small_frame();
    test_backpressure();
    test_credit();
    test_underflow();
    test_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
